// File: rtl/rgb_division_if.sv
// Request/response bundle for the colour-channel divider: start/a/b in, busy/result/valid out.
interface rgb_division_if;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic [7:0] result;
  logic       valid;

  modport master (output start, a, b, input busy, result, valid);
  modport slave  (input start, a, b, output busy, result, valid);
endinterface

// File: rtl/rgb_division.sv
// Iterative restoring divider: result = min(255, floor(a*256/b)), optional round half-up,
// fixed latency of 8/BITS_PER_CYCLE + 1 cycles from the accepting edge.
module rgb_division #(
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter bit          ROUND          = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  rgb_division_if.slave bus
);

  localparam int unsigned K = 8 / BITS_PER_CYCLE;

  typedef enum logic [1:0] {IDLE, DIV, FINISH} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [8:0] r_rem;
  logic [7:0] r_b;
  logic [7:0] r_q;
  logic [3:0] r_cnt;
  logic       r_sat;
  logic [7:0] r_result;
  logic       r_valid;

  logic [8:0] w_rem;
  logic [7:0] w_q;
  logic [9:0] w_rem2;
  logic       w_round_up;
  logic [7:0] w_final;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = DIV;
      DIV:     if (r_cnt == 4'd1) w_next = FINISH;
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Remainder stays below b between steps, so the doubled value always fits in 9 bits.
  always_comb begin
    w_rem = r_rem;
    w_q   = r_q;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      w_rem = {w_rem[7:0], 1'b0};
      if (w_rem >= {1'b0, r_b}) begin
        w_rem = w_rem - {1'b0, r_b};
        w_q   = {w_q[6:0], 1'b1};
      end else begin
        w_q   = {w_q[6:0], 1'b0};
      end
    end
  end

  always_comb begin
    w_rem2     = {r_rem, 1'b0};
    w_round_up = ROUND && (w_rem2 >= {2'b00, r_b}) && (r_q != 8'hFF);
    if (r_sat)           w_final = 8'hFF;
    else if (w_round_up) w_final = r_q + 8'd1;
    else                 w_final = r_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem    <= '0;
      r_b      <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_sat    <= 1'b0;
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_b   <= bus.b;
            r_sat <= (bus.b == 8'd0) || (bus.a >= bus.b);
            r_rem <= ((bus.b == 8'd0) || (bus.a >= bus.b)) ? 9'd0 : {1'b0, bus.a};
            r_q   <= '0;
            r_cnt <= 4'(K);
          end
        end
        DIV: begin
          r_rem <= w_rem;
          r_q   <= w_q;
          r_cnt <= r_cnt - 4'd1;
        end
        FINISH: begin
          r_result <= w_final;
          r_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (r_state != IDLE);
  assign bus.result = r_result;
  assign bus.valid  = r_valid;

endmodule

// File: tb/tb_rgb_division.sv
// Bench for rgb_division: three configurations driven in parallel, cycle-accurate scoreboard.
module tb_rgb_division;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] tr;
    logic [7:0] rd;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    int         due;
  } exp_t;

  localparam int NI = 3;
  localparam int KK [NI] = '{8, 8, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic       t_start;
  logic [7:0] t_a;
  logic [7:0] t_b;
  logic [7:0] exp_tr;
  logic [7:0] exp_rd;

  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  bit   armed  = 1'b0;
  exp_t sbq [NI][$];
  logic [7:0] held [NI];

  logic       busy_v  [NI];
  logic       valid_v [NI];
  logic [7:0] res_v   [NI];

  vec_t tbl [12];

  rgb_division_if bus0 ();
  rgb_division_if bus1 ();
  rgb_division_if bus2 ();

  assign bus0.start = t_start;  assign bus0.a = t_a;  assign bus0.b = t_b;
  assign bus1.start = t_start;  assign bus1.a = t_a;  assign bus1.b = t_b;
  assign bus2.start = t_start;  assign bus2.a = t_a;  assign bus2.b = t_b;

  assign busy_v[0] = bus0.busy;  assign valid_v[0] = bus0.valid;  assign res_v[0] = bus0.result;
  assign busy_v[1] = bus1.busy;  assign valid_v[1] = bus1.valid;  assign res_v[1] = bus1.result;
  assign busy_v[2] = bus2.busy;  assign valid_v[2] = bus2.valid;  assign res_v[2] = bus2.result;

  rgb_division #(.BITS_PER_CYCLE(1), .ROUND(1'b0)) u_trunc (.clk(clk), .rst(rst), .bus(bus0));
  rgb_division #(.BITS_PER_CYCLE(1), .ROUND(1'b1)) u_round (.clk(clk), .rst(rst), .bus(bus1));
  rgb_division #(.BITS_PER_CYCLE(8), .ROUND(1'b0)) u_fast  (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b, input bit rnd);
    int unsigned num, q, r;
    if (b == 8'd0 || a >= b) return 8'hFF;
    num = 256 * int'(a);
    q   = num / int'(b);
    r   = num % int'(b);
    if (rnd && (2 * r >= int'(b)) && q < 255) q++;
    return 8'(q);
  endfunction

  task automatic chk(input string nm, input int i, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at edge %0d: got %0d expected %0d", nm, i, edge_n, act, exp);
    end
  endtask

  // Reference timing: a start is taken only when the instance has nothing outstanding;
  // its result is due K+1 edges after the accepting edge.
  always @(posedge clk) begin
    edge_n++;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        sbq[i].delete();
        held[i] = '0;
      end else if (t_start && sbq[i].size() == 0) begin
        sbq[i].push_back('{res: (i == 1) ? exp_rd : exp_tr, due: edge_n + KK[i] + 1});
      end
    end
    if (rst) armed = 1'b1;
  end

  always @(negedge clk) begin
    bit         ev, be;
    logic [7:0] er;
    if (armed) begin
      for (int i = 0; i < NI; i++) begin
        ev = (sbq[i].size() > 0) && (sbq[i][0].due == edge_n);
        be = (sbq[i].size() > 0) && (sbq[i][0].due >  edge_n);
        er = ev ? sbq[i][0].res : held[i];
        chk("busy",   i, {7'd0, busy_v[i]},  {7'd0, be});
        chk("valid",  i, {7'd0, valid_v[i]}, {7'd0, ev});
        chk("result", i, res_v[i], er);
        if (ev) begin
          held[i] = er;
          void'(sbq[i].pop_front());
        end
      end
    end
  end

  task automatic set_req(input logic s, input logic [7:0] a, input logic [7:0] b);
    t_start = s;
    t_a     = a;
    t_b     = b;
    exp_tr  = model(a, b, 1'b0);
    exp_rd  = model(a, b, 1'b1);
  endtask

  initial begin
    tbl[0]  = '{a: 8'd128, b: 8'd255, tr: 8'd128, rd: 8'd129};
    tbl[1]  = '{a: 8'd100, b: 8'd128, tr: 8'd200, rd: 8'd200};
    tbl[2]  = '{a: 8'd1,   b: 8'd255, tr: 8'd1,   rd: 8'd1};
    tbl[3]  = '{a: 8'd0,   b: 8'd7,   tr: 8'd0,   rd: 8'd0};
    tbl[4]  = '{a: 8'd50,  b: 8'd0,   tr: 8'd255, rd: 8'd255};
    tbl[5]  = '{a: 8'd200, b: 8'd100, tr: 8'd255, rd: 8'd255};
    tbl[6]  = '{a: 8'd77,  b: 8'd77,  tr: 8'd255, rd: 8'd255};
    tbl[7]  = '{a: 8'd254, b: 8'd255, tr: 8'd254, rd: 8'd255};
    tbl[8]  = '{a: 8'd3,   b: 8'd7,   tr: 8'd109, rd: 8'd110};
    tbl[9]  = '{a: 8'd1,   b: 8'd2,   tr: 8'd128, rd: 8'd128};
    tbl[10] = '{a: 8'd10,  b: 8'd20,  tr: 8'd128, rd: 8'd128};
    tbl[11] = '{a: 8'd5,   b: 8'd9,   tr: 8'd142, rd: 8'd142};

    rst = 1'b1;
    t_start = 1'b0; t_a = '0; t_b = '0; exp_tr = '0; exp_rd = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    for (int n = 0; n < 12; n++) begin
      t_start = 1'b1;
      t_a     = tbl[n].a;
      t_b     = tbl[n].b;
      exp_tr  = tbl[n].tr;
      exp_rd  = tbl[n].rd;
      @(negedge clk);
      t_start = 1'b0;
      repeat (10) @(negedge clk);
      chk("tbl_trunc", n, res_v[0], tbl[n].tr);
      chk("tbl_round", n, res_v[1], tbl[n].rd);
      chk("tbl_fast",  n, res_v[2], tbl[n].tr);
    end

    // Starts while busy at cycles 3 and 5, then a start in the valid cycle of the first op.
    for (int c = 0; c < 22; c++) begin
      if (c == 0)                set_req(1'b1, 8'd64, 8'd128);
      else if (c == 3 || c == 5) set_req(1'b1, 8'd1,  8'd2);
      else if (c == 10)          set_req(1'b1, 8'd32, 8'd64);
      else                       set_req(1'b0, 8'd0,  8'd0);
      @(negedge clk);
    end
    chk("b2b_trunc", 0, res_v[0], 8'd128);

    // Reset in the middle of an operation, then a clean restart.
    for (int c = 0; c < 20; c++) begin
      rst = (c == 4);
      if (c == 0 || c == 6) set_req(1'b1, 8'd10, 8'd20);
      else                  set_req(1'b0, 8'd0,  8'd0);
      @(negedge clk);
    end
    chk("rst_restart", 0, res_v[0], 8'd128);
    chk("rst_restart", 1, res_v[1], 8'd128);

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
